// File: rtl/nibble_lut_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier that accumulates one 4x4 nibble product per clock.
// Define MUL_ZERO_SKIP_EN to bypass the compute phase when either operand is zero.
module nibble_lut_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N  = WIDTH / 4;
    localparam int TW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("nibble_lut_multiplier: WIDTH must be a multiple of 4 and at least 4");
    end

    function automatic logic [7:0] lut(input logic [3:0] x, input logic [3:0] y);
        lut = {4'b0000, x} * {4'b0000, y};
    endfunction

    logic [1:0]        state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [TW-1:0]     acc;
    logic [CW-1:0]     i_cnt;
    logic [CW-1:0]     j_cnt;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [7:0]        lut_out;
    logic [CW+2:0]     shift_amt;
    logic [TW-1:0]     term;
    logic [TW-1:0]     acc_next;

    // Current nibble pair, its table product and its weight 2^(4*(i+j)).
    always_comb begin
        nib_a     = a_reg[{i_cnt, 2'b00} +: 4];
        nib_b     = b_reg[{j_cnt, 2'b00} +: 4];
        lut_out   = lut(nib_a, nib_b);
        shift_amt = {1'b0, i_cnt, 2'b00} + {1'b0, j_cnt, 2'b00};
        term      = TW'(lut_out) << shift_amt;
        acc_next  = acc + term;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
`ifdef MUL_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            product <= '0;
                            state   <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (i_cnt == LAST && j_cnt == LAST) begin
                        product <= acc_next;
                        state   <= DONE;
                    end else if (j_cnt == LAST) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nibble_lut_multiplier.sv
// Scoreboard bench for nibble_lut_multiplier at WIDTH=8 and WIDTH=16.
// Honours MUL_ZERO_SKIP_EN when computing expected latency.
module tb_nibble_lut_multiplier;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc8 = 0;
    bit   rand_bp = 0;
    exp_t q8[$];
    exp_t q16[$];

    nibble_lut_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    nibble_lut_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .product(product16), .busy(busy16)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // Reference: product is plain arithmetic, latency is nibbles squared unless zero-skip applies.
    function automatic int expLat(input int width, input logic [63:0] x, input logic [63:0] y);
`ifdef MUL_ZERO_SKIP_EN
        if (x == 0 || y == 0) return 0;
`endif
        return (width / 4) * (width / 4);
    endfunction

    task automatic applyStimulus8(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        a8 = x;
        b8 = y;
        in_valid8 = 1;
        while (!in_ready8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            failNow("accept8");
            in_valid8 = 0;
            return;
        end
        e.prod    = 64'(x) * 64'(y);
        e.acc_cyc = cyc + 1;
        e.lat     = expLat(8, 64'(x), 64'(y));
        last_acc8 = e.acc_cyc;
        q8.push_back(e);
        @(posedge clk);
        #1;
        in_valid8 = 0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        checkOutput("in_ready8_after_accept", 64'(in_ready8), 64'd0);
    endtask

    task automatic applyStimulus16(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        a16 = x;
        b16 = y;
        in_valid16 = 1;
        while (!in_ready16 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            failNow("accept16");
            in_valid16 = 0;
            return;
        end
        e.prod    = 64'(x) * 64'(y);
        e.acc_cyc = cyc + 1;
        e.lat     = expLat(16, 64'(x), 64'(y));
        q16.push_back(e);
        @(posedge clk);
        #1;
        in_valid16 = 0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0 || !in_ready8 || !in_ready16) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) failNow("drain");
    endtask

    // Monitor for the 8-bit instance: latency, stability under backpressure, and value.
    bit pend8 = 0;
    int first8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (pend8 && !out_valid8 && rst_n) begin
            $display("[TB] FAIL out_valid8_dropped: actual=0 required=1");
            errors++;
            checks++;
            pend8 = 0;
        end
        if (out_valid8 && rst_n) begin
            if (!pend8) begin
                pend8 = 1;
                first8 = cyc;
            end
            if (out_ready8) begin
                pend8 = 0;
                if (q8.size() == 0) begin
                    $display("[TB] FAIL unexpected8: actual=0x%0h required=no output", product8);
                    errors++;
                    checks++;
                end else begin
                    e = q8.pop_front();
                    checkOutput("product8", 64'(product8), e.prod);
                    checkOutput("latency8", 64'(first8 - e.acc_cyc), 64'(e.lat));
                end
            end
        end
    end

    bit pend16 = 0;
    int first16 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid16 && rst_n) begin
            if (!pend16) begin
                pend16 = 1;
                first16 = cyc;
            end
            if (out_ready16) begin
                pend16 = 0;
                if (q16.size() == 0) begin
                    $display("[TB] FAIL unexpected16: actual=0x%0h required=no output", product16);
                    errors++;
                    checks++;
                end else begin
                    e = q16.pop_front();
                    checkOutput("product16", 64'(product16), e.prod);
                    checkOutput("latency16", 64'(first16 - e.acc_cyc), 64'(e.lat));
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_bp) out_ready8 = 1'($urandom_range(0, 1));
    end

    initial begin
        int t_first;
        logic [7:0] x, y;
        logic [15:0] bp_exp;
        int n;

        rst_n = 0;
        in_valid8 = 0;  a8 = 0;  b8 = 0;  out_ready8 = 1;
        in_valid16 = 0; a16 = 0; b16 = 0; out_ready16 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready8), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid8), 64'd0);
        checkOutput("reset_busy", 64'(busy8), 64'd0);
        checkOutput("reset_product8", 64'(product8), 64'd0);
        checkOutput("reset_product16", 64'(product16), 64'd0);
        rst_n = 1;

        applyStimulus8(8'h0F, 8'h0F);
        drain();

        applyStimulus8(8'h12, 8'h34);
        t_first = last_acc8;
        applyStimulus8(8'hFF, 8'hFF);
        checkOutput("throughput8", 64'(last_acc8 - t_first), 64'd6);
        drain();

        // Hold the result under backpressure while fresh operands are offered.
        @(negedge clk);
        out_ready8 = 0;
        x = 8'($urandom);
        y = 8'($urandom);
        bp_exp = 16'(x) * 16'(y);
        applyStimulus8(x, y);
        n = 0;
        while (!out_valid8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) failNow("bp_out_valid");
        repeat (10) begin
            @(negedge clk);
            in_valid8 = 1;
            a8 = 8'h01;
            b8 = 8'h01;
            checkOutput("bp_product", 64'(product8), 64'(bp_exp));
            checkOutput("bp_out_valid", 64'(out_valid8), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready8), 64'd0);
            checkOutput("bp_busy", 64'(busy8), 64'd1);
        end
        in_valid8 = 0;
        out_ready8 = 1;
        drain();
        applyStimulus8(8'h01, 8'h01);
        drain();

        // Abort 0xAB*0xCD with reset during its second compute cycle.
        @(negedge clk);
        a8 = 8'hAB;
        b8 = 8'hCD;
        in_valid8 = 1;
        @(posedge clk);
        #1;
        in_valid8 = 0;
        @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_out_valid", 64'(out_valid8), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready8), 64'd1);
        checkOutput("abort_product", 64'(product8), 64'd0);
        checkOutput("abort_busy", 64'(busy8), 64'd0);
        rst_n = 1;
        applyStimulus8(8'h02, 8'h03);
        drain();

        applyStimulus8(8'h00, 8'h5A);
        applyStimulus8(8'h77, 8'h00);
        drain();

        rand_bp = 1;
        repeat (40) begin
            x = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            y = 8'($urandom);
            applyStimulus8(x, y);
        end
        drain();
        rand_bp = 0;
        @(posedge clk);
        #2;
        out_ready8 = 1;

        applyStimulus16(16'hFFFF, 16'hFFFF);
        applyStimulus16(16'h1234, 16'h0010);
        applyStimulus16(16'h0000, 16'hBEEF);
        repeat (8) applyStimulus16(16'($urandom), 16'($urandom));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
